// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared codes and constants for the sprite character engine
package sprite_pkg;

    localparam int COLOUR_W = 6;
    localparam logic [COLOUR_W-1:0] TRANSPARENT_DEFAULT = 6'h3F;

    typedef enum logic [2:0] {
        NO_ACTION = 3'd0,
        ATTACK    = 3'd1,
        UP        = 3'd2,
        DOWN      = 3'd3,
        LEFT      = 3'd4,
        RIGHT     = 3'd5
    } action_e;

    typedef enum logic [1:0] {
        F_UP    = 2'd0,
        F_DOWN  = 2'd1,
        F_LEFT  = 2'd2,
        F_RIGHT = 2'd3
    } facing_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } draw_state_e;

endpackage

// File: rtl/sprite_char_engine_draw_pipe.sv
// rtl/sprite_char_engine_draw_pipe.sv - pixel counter, sheet addressing and ROM-latency alignment
module sprite_draw_pipe
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int SHEET_W  = 192,
    parameter int AW       = 12,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                run,
    input  logic                abort,
    input  logic [8:0]          base_x,
    input  logic [7:0]          base_y,
    input  logic [AW-1:0]       base_col,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic                last,
    output logic [AW-1:0]       rom_addr,
    output logic [8:0]          x_draw,
    output logic [7:0]          y_draw,
    output logic [COLOUR_W-1:0] colour,
    output logic                vga_write
);

    localparam int N   = SPRITE_W * SPRITE_H;
    localparam int KW  = $clog2(N);
    localparam int DXW = $clog2(SPRITE_W);

    logic [KW-1:0]     k;
    logic [8:0]        lx;
    logic [7:0]        ly;
    logic [AW-1:0]     lcol;
    logic              valid_d;
    logic [DXW-1:0]    dx;
    logic [KW-DXW-1:0] dy;
    int                addr_i;

    assign dx   = k[DXW-1:0];
    assign dy   = k[KW-1:DXW];
    assign last = run && (k == KW'(N - 1));

    always_comb begin
        addr_i   = int'(dy) * SHEET_W + int'(lcol) + int'(dx);
        rom_addr = AW'(addr_i);
    end

    // Coordinates trail the address by one cycle so they line up with rom_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k       <= '0;
            lx      <= '0;
            ly      <= '0;
            lcol    <= '0;
            valid_d <= 1'b0;
            x_draw  <= '0;
            y_draw  <= '0;
        end else begin
            valid_d <= run && !abort;
            if (start) begin
                k    <= '0;
                lx   <= base_x;
                ly   <= base_y;
                lcol <= base_col;
            end else if (run) begin
                k <= k + 1'b1;
            end
            if (run) begin
                x_draw <= lx + 9'(dx);
                y_draw <= ly + 8'(dy);
            end
        end
    end

    assign vga_write = valid_d && (rom_q != TRANSPARENT);
    assign colour    = valid_d ? rom_q : '0;

endmodule

// File: rtl/sprite_char_engine.sv
// rtl/sprite_char_engine.sv - moves, animates and draws one sprite-sheet character
module sprite_char_engine
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int FRAMES     = 2,
    parameter int STEP       = 1,
    parameter int X_MAX      = 320,
    parameter int Y_MAX      = 240,
    parameter int INIT_X     = 127,
    parameter int INIT_Y     = 88,
    parameter int ANIM_DIV   = 4,
    parameter int ATTACK_LEN = 8,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT,
    localparam int SHEET_W   = 4 * (FRAMES + 1) * SPRITE_W,
    localparam int AW        = $clog2(SHEET_W * SPRITE_H)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                init,
    input  logic                apply_action,
    input  logic                draw_char,
    input  logic [2:0]          user_input,
    input  logic [3:0]          collision,
    output logic [AW-1:0]       rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [8:0]          x_pos,
    output logic [7:0]          y_pos,
    output logic [8:0]          x_draw,
    output logic [7:0]          y_draw,
    output logic [COLOUR_W-1:0] colour,
    output logic                vga_write,
    output logic [1:0]          facing,
    output logic                attacking,
    output logic                draw_done
);

    localparam int X_LIM      = X_MAX - SPRITE_W;
    localparam int Y_LIM      = Y_MAX - SPRITE_H;
    localparam int ANIM_TOTAL = ANIM_DIV * FRAMES;
    localparam int ANIM_W     = (ANIM_TOTAL > 1) ? $clog2(ANIM_TOTAL) : 1;
    localparam int ATK_W      = $clog2(ATTACK_LEN + 1);

    draw_state_e       state, state_next;
    logic [ANIM_W-1:0] anim_cnt;
    logic [ATK_W-1:0]  attack_timer;
    logic [8:0]        nx;
    logic [7:0]        ny;
    logic [1:0]        nf;
    logic              moved;
    logic              action_ok;
    logic              draw_start;
    logic              draw_last;
    logic [AW-1:0]     sprite_col;
    int                x_try, y_try, col_idx;

    assign action_ok  = apply_action && !init && (state == IDLE);
    assign draw_start = draw_char && !apply_action && !init && (state == IDLE);

    always_comb begin
        x_try = int'(x_pos);
        y_try = int'(y_pos);
        nf    = facing;
        case (user_input)
            UP:    begin nf = F_UP;    if (!collision[0]) y_try = int'(y_pos) - STEP; end
            DOWN:  begin nf = F_DOWN;  if (!collision[1]) y_try = int'(y_pos) + STEP; end
            LEFT:  begin nf = F_LEFT;  if (!collision[2]) x_try = int'(x_pos) - STEP; end
            RIGHT: begin nf = F_RIGHT; if (!collision[3]) x_try = int'(x_pos) + STEP; end
            default: ;
        endcase
        if (x_try < 0) x_try = 0;
        else if (x_try > X_LIM) x_try = X_LIM;
        if (y_try < 0) y_try = 0;
        else if (y_try > Y_LIM) y_try = Y_LIM;
        nx    = 9'(x_try);
        ny    = 8'(y_try);
        moved = (nx != x_pos) || (ny != y_pos);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_pos        <= '0;
            y_pos        <= '0;
            facing       <= F_DOWN;
            attacking    <= 1'b0;
            attack_timer <= '0;
            anim_cnt     <= '0;
        end else if (init) begin
            x_pos        <= 9'(INIT_X);
            y_pos        <= 8'(INIT_Y);
            facing       <= F_DOWN;
            attacking    <= 1'b0;
            attack_timer <= '0;
            anim_cnt     <= '0;
        end else if (action_ok) begin
            if (attacking) begin
                // The attack pulse itself counts as the first of ATTACK_LEN.
                if (attack_timer <= ATK_W'(1)) begin
                    attacking    <= 1'b0;
                    attack_timer <= '0;
                end else begin
                    attack_timer <= attack_timer - 1'b1;
                end
            end else if (user_input == ATTACK) begin
                attacking    <= 1'b1;
                attack_timer <= ATK_W'(ATTACK_LEN - 1);
            end else begin
                facing <= nf;
                x_pos  <= nx;
                y_pos  <= ny;
                if (moved)
                    anim_cnt <= (anim_cnt == ANIM_W'(ANIM_TOTAL - 1)) ? '0 : anim_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        col_idx    = int'(facing) * (FRAMES + 1) + (attacking ? FRAMES : int'(anim_cnt) / ANIM_DIV);
        sprite_col = AW'(col_idx * SPRITE_W);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        draw_done  = (state == DONE);
        if (init) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (draw_start) state_next = DRAW;
                DRAW:    if (draw_last)  state_next = FLUSH;
                FLUSH:   state_next = DONE;
                DONE:    if (!draw_char) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    sprite_draw_pipe #(
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .SHEET_W     (SHEET_W),
        .AW          (AW),
        .TRANSPARENT (TRANSPARENT)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .start     (draw_start),
        .run       (state == DRAW),
        .abort     (init),
        .base_x    (x_pos),
        .base_y    (y_pos),
        .base_col  (sprite_col),
        .rom_q     (rom_q),
        .last      (draw_last),
        .rom_addr  (rom_addr),
        .x_draw    (x_draw),
        .y_draw    (y_draw),
        .colour    (colour),
        .vga_write (vga_write)
    );

endmodule

// File: tb/tb_sprite_char_engine.sv
// tb/tb_sprite_char_engine.sv - self-checking bench for sprite_char_engine
module tb_sprite_char_engine;
    import sprite_pkg::*;

    localparam int SHEET_W = 192;
    localparam int XLIM    = 304;
    localparam int YLIM    = 224;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0, apply_action = 1'b0, draw_char = 1'b0;
    logic [2:0]  user_input = 3'd0;
    logic [3:0]  collision = 4'd0;
    logic [11:0] rom_addr;
    logic [5:0]  rom_q = 6'd0;
    logic [8:0]  x_pos, x_draw;
    logic [7:0]  y_pos, y_draw;
    logic [5:0]  colour;
    logic        vga_write, attacking, draw_done;
    logic [1:0]  facing;

    logic [5:0]  rom [0:3071];

    sprite_char_engine dut (
        .clock(clock), .reset(reset), .init(init), .apply_action(apply_action),
        .draw_char(draw_char), .user_input(user_input), .collision(collision),
        .rom_addr(rom_addr), .rom_q(rom_q), .x_pos(x_pos), .y_pos(y_pos),
        .x_draw(x_draw), .y_draw(y_draw), .colour(colour), .vga_write(vga_write),
        .facing(facing), .attacking(attacking), .draw_done(draw_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) rom_q <= rom[rom_addr];

    int n_cmp = 0, n_err = 0;
    int m_x, m_y, m_f, m_att, m_left, m_moves;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_init();
        m_x = 127; m_y = 88; m_f = 1; m_att = 0; m_left = 0; m_moves = 0;
    endtask

    task automatic model_apply(input int ui, input int col);
        int dxs[4] = '{0, 0, -1, 1};
        int dys[4] = '{-1, 1, 0, 0};
        int f, tx, ty;
        if (m_att != 0) begin
            m_left--;
            if (m_left <= 0) m_att = 0;
        end else if (ui == 1) begin
            m_att = 1;
            m_left = 7;
        end else if (ui >= 2 && ui <= 5) begin
            f = ui - 2;
            m_f = f;
            if (((col >> f) & 1) == 0) begin
                tx = m_x + dxs[f];
                ty = m_y + dys[f];
                tx = (tx < 0) ? 0 : (tx > XLIM ? XLIM : tx);
                ty = (ty < 0) ? 0 : (ty > YLIM ? YLIM : ty);
                if (tx != m_x || ty != m_y) m_moves++;
                m_x = tx;
                m_y = ty;
            end
        end
    endtask

    task automatic do_action(input int ui, input int col);
        user_input = 3'(ui);
        collision = 4'(col);
        apply_action = 1'b1;
        tick();
        apply_action = 1'b0;
        model_apply(ui, col);
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        model_init();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_x"}, int'(x_pos), m_x);
        chk({tag, "_y"}, int'(y_pos), m_y);
        chk({tag, "_facing"}, int'(facing), m_f);
        chk({tag, "_attacking"}, int'(attacking), m_att);
    endtask

    // Full draw against the model; exp_col < 0 derives the sheet column from the model.
    task automatic do_draw(input int exp_col, output int writes);
        int c, dx, dy, e, errs, got;
        bit ew;
        c = (exp_col >= 0) ? exp_col
            : (m_f * 3 + ((m_att != 0) ? 2 : (m_moves / 4) % 2)) * 16;
        writes = 0; got = 0; errs = 0;
        draw_char = 1'b1;
        tick();
        chk("first_rom_addr", int'(rom_addr), c);
        for (int i = 0; i < 256; i++) begin
            tick();
            dx = i % 16;
            dy = i / 16;
            e  = int'(rom[dy * SHEET_W + c + dx]);
            ew = (e != 63);
            if (i == 0) begin
                chk("first_x_draw", int'(x_draw), m_x);
                chk("first_y_draw", int'(y_draw), m_y);
            end
            if (vga_write != ew) errs++;
            if (ew) begin
                writes++;
                if (int'(x_draw) != m_x + dx || int'(y_draw) != m_y + dy || int'(colour) != e) errs++;
            end
            if (vga_write) got++;
        end
        chk("done_before_257", int'(draw_done), 0);
        chk("pixel_stream_errors", errs, 0);
        chk("write_count", got, writes);
        tick();
        chk("done_at_257", int'(draw_done), 1);
        user_input = 3'd5; collision = 4'd0; apply_action = 1'b1;
        tick();
        apply_action = 1'b0;
        chk("action_ignored_in_done", int'(x_pos), m_x);
        draw_char = 1'b0;
        tick();
        chk("done_cleared", int'(draw_done), 0);
    endtask

    typedef struct {
        int ui;
        int col;
        int ex, ey, ef, ea;
    } vec_t;

    vec_t vecs[14];
    int   w;

    initial begin
        vecs[0]  = '{5, 4'b0000, 128, 88, 3, 0};
        vecs[1]  = '{5, 4'b0000, 129, 88, 3, 0};
        vecs[2]  = '{5, 4'b0000, 130, 88, 3, 0};
        vecs[3]  = '{2, 4'b0001, 130, 88, 0, 0};
        vecs[4]  = '{4, 4'b0100, 130, 88, 2, 0};
        vecs[5]  = '{3, 4'b0010, 130, 88, 1, 0};
        vecs[6]  = '{3, 4'b0000, 130, 89, 1, 0};
        vecs[7]  = '{6, 4'b0000, 130, 89, 1, 0};
        vecs[8]  = '{7, 4'b0000, 130, 89, 1, 0};
        vecs[9]  = '{4, 4'b1011, 129, 89, 2, 0};
        vecs[10] = '{2, 4'b1110, 129, 88, 0, 0};
        vecs[11] = '{1, 4'b0000, 129, 88, 0, 1};
        vecs[12] = '{5, 4'b0000, 129, 88, 0, 1};
        vecs[13] = '{0, 4'b0000, 129, 88, 0, 1};

        for (int i = 0; i < 3072; i++) rom[i] = 6'd5;

        // Reset values while reset is held low
        tick(); tick();
        chk("rst_x_pos", int'(x_pos), 0);
        chk("rst_y_pos", int'(y_pos), 0);
        chk("rst_facing", int'(facing), 1);
        chk("rst_attacking", int'(attacking), 0);
        chk("rst_draw_done", int'(draw_done), 0);
        chk("rst_vga_write", int'(vga_write), 0);
        chk("rst_x_draw", int'(x_draw), 0);
        chk("rst_colour", int'(colour), 0);
        reset = 1'b1;
        tick();
        do_init();
        check_state("init");

        // Table-driven action vectors
        for (int i = 0; i < 14; i++) begin
            do_action(vecs[i].ui, vecs[i].col);
            chk($sformatf("vec%0d_x", i), int'(x_pos), vecs[i].ex);
            chk($sformatf("vec%0d_y", i), int'(y_pos), vecs[i].ey);
            chk($sformatf("vec%0d_facing", i), int'(facing), vecs[i].ef);
            chk($sformatf("vec%0d_attacking", i), int'(attacking), vecs[i].ea);
        end

        // Attack lasts 8 pulses including the attack itself
        do_init();
        do_action(1, 0);
        chk("atk_set", int'(attacking), 1);
        for (int i = 0; i < 6; i++) do_action(3, 0);
        chk("atk_after6", int'(attacking), 1);
        do_action(3, 0);
        chk("atk_after7", int'(attacking), 0);
        chk("atk_y_held", int'(y_pos), 88);
        do_action(3, 0);
        chk("atk_next_moves", int'(y_pos), 89);

        // Attack column while attacking
        do_init();
        do_action(1, 0);
        do_draw(80, w);

        // Top edge clamp; anim count 95 puts a wrong increment across a frame boundary
        do_init();
        do_action(4, 0);
        for (int i = 0; i < 3; i++) do_action(3, 0);
        for (int i = 0; i < 91; i++) do_action(2, 0);
        chk("top_reached", int'(y_pos), 0);
        do_action(2, 0);
        chk("top_clamped", int'(y_pos), 0);
        do_draw(16, w);

        // Right edge clamp with the same frame-boundary setup
        do_init();
        for (int i = 0; i < 3; i++) do_action(3, 0);
        for (int i = 0; i < 3; i++) do_action(2, 0);
        for (int i = 0; i < 177; i++) do_action(5, 0);
        chk("right_reached", int'(x_pos), 304);
        do_action(5, 0);
        chk("right_clamped", int'(x_pos), 304);
        do_draw(160, w);

        // Four right moves -> frame 1, even pixels transparent
        for (int i = 0; i < 3072; i++) rom[i] = ((i % 2) == 0) ? 6'h3F : 6'(i % 32);
        do_init();
        for (int i = 0; i < 4; i++) do_action(5, 0);
        check_state("four_right");
        do_draw(160, w);
        chk("even_key_writes", w, 128);

        // init aborts a draw in progress
        for (int i = 0; i < 3072; i++) rom[i] = 6'd9;
        draw_char = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_pre_write", int'(vga_write), 1);
        init = 1'b1; draw_char = 1'b0;
        tick();
        init = 1'b0;
        model_init();
        chk("abort_write_off", int'(vga_write), 0);
        chk("abort_x_pos", int'(x_pos), 127);
        tick();
        chk("abort_idle_done", int'(draw_done), 0);
        chk("abort_idle_write", int'(vga_write), 0);

        // Randomised actions, inits and draws against the model
        for (int i = 0; i < 3072; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) do_init();
            else if (r < 10) do_draw(-1, w);
            else do_action($urandom_range(0, 7), $urandom_range(0, 15) & $urandom_range(0, 15));
            check_state("rand");
        end

        // Reset asserted mid-draw clears outputs immediately
        for (int i = 0; i < 3072; i++) rom[i] = 6'd12;
        draw_char = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_pre_write", int'(vga_write), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_write", int'(vga_write), 0);
        chk("mid_rst_x_pos", int'(x_pos), 0);
        chk("mid_rst_x_draw", int'(x_draw), 0);
        chk("mid_rst_colour", int'(colour), 0);
        chk("mid_rst_facing", int'(facing), 1);
        draw_char = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_done", int'(draw_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
